// File: rtl/fir_mac_seq.sv
// fir_mac_seq: single-MAC time-multiplexed FIR, one tap per clock; define FIR_SAT_EN to saturate the output instead of wrapping
module fir_mac_seq #(
  parameter int N_TAPS = 8,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 16,
  parameter int SHIFT = 0,
  localparam int AW = DW + CW + $clog2(N_TAPS),
  localparam int AAW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DW-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [OW-1:0]  out_data,
  input  logic                  coef_we,
  input  logic [AAW-1:0]        coef_addr,
  input  logic signed [CW-1:0]  coef_wdata,
  output logic                  busy
);
  localparam int RW = (AW + 1 > OW) ? AW + 1 : OW;
  localparam logic signed [AW:0] RND = ((AW + 1)'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state_q, state_d;
  logic signed [DW-1:0] d_q [N_TAPS];
  logic signed [DW-1:0] d_d [N_TAPS];
  logic signed [CW-1:0] c_q [N_TAPS];
  logic signed [CW-1:0] c_d [N_TAPS];
  logic signed [AW-1:0] acc_q, acc_d, acc_sum;
  logic [AAW-1:0] k_q, k_d;
  logic signed [OW-1:0] out_data_q, out_data_d;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW:0] rnd_sum, r_sh;
  logic signed [RW-1:0] r;
  logic signed [OW-1:0] r_n;
  logic last;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign busy = state_q != IDLE;
  assign out_data = out_data_q;
  assign last = k_q == AAW'(N_TAPS - 1);
  // Current tap product folded into the running sum, then rounded, shifted and narrowed
  always_comb begin
    prod = d_q[k_q] * c_q[k_q];
    acc_sum = acc_q + {{(AW - DW - CW){prod[DW+CW-1]}}, prod};
    rnd_sum = {acc_sum[AW-1], acc_sum} + RND;
    r_sh = rnd_sum >>> SHIFT;
    r = RW'(r_sh);
`ifdef FIR_SAT_EN
    r_n = (r > MAXV) ? MAXV[OW-1:0] : (r < MINV) ? MINV[OW-1:0] : r[OW-1:0];
`else
    r_n = OW'(r);
`endif
  end
  // Next state: coefficient writes and sample shift-in in IDLE, one tap per MAC cycle, hold result in OUT
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    k_d = k_q;
    out_data_d = out_data_q;
    d_d = d_q;
    c_d = c_q;
    if (state_q == IDLE) begin
      for (int j = 0; j < N_TAPS; j++)
        if (coef_we && coef_addr == AAW'(j)) c_d[j] = coef_wdata;
      if (in_valid) begin
        d_d[0] = in_data;
        for (int j = 1; j < N_TAPS; j++) d_d[j] = d_q[j-1];
        acc_d = '0;
        k_d = '0;
        state_d = MAC;
      end
    end else if (state_q == MAC) begin
      acc_d = acc_sum;
      k_d = k_q + 1'b1;
      if (last) begin
        out_data_d = r_n;
        state_d = OUT;
      end
    end else begin
      state_d = out_ready ? IDLE : state_q;
    end
  end
  // State register; reset clears delay line, coefficients and any partial result
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      acc_q <= '0;
      k_q <= '0;
      out_data_q <= '0;
      for (int j = 0; j < N_TAPS; j++) begin
        d_q[j] <= '0;
        c_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      k_q <= k_d;
      out_data_q <= out_data_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed tests of fir_mac_seq across four parameterisations
module tb_fir_mac_seq;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic out_ready = 1'b1;
  logic signed [7:0] in_data = '0;
  logic signed [7:0] coef_wdata = '0;
  logic [2:0] coef_addr = '0;
  logic [3:0] iv = '0;
  logic [3:0] cw = '0;
  logic [3:0] ir, ov, by;
  logic [3:0][15:0] od;
  logic signed [7:0] od_s;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  assign od[1] = {{8{od_s[7]}}, od_s};
  fir_mac_seq #(.N_TAPS(4)) u_a (
    .clk(clk), .res(res), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .coef_we(cw[0]),
    .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata), .busy(by[0]));
  fir_mac_seq #(.N_TAPS(4), .OW(8)) u_s (
    .clk(clk), .res(res), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_s), .coef_we(cw[1]),
    .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata), .busy(by[1]));
  fir_mac_seq #(.N_TAPS(4), .SHIFT(2)) u_r (
    .clk(clk), .res(res), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .coef_we(cw[2]),
    .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata), .busy(by[2]));
  fir_mac_seq #(.N_TAPS(6)) u_6 (
    .clk(clk), .res(res), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .coef_we(cw[3]),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(by[3]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int i, input int a, input int v);
    cw[i] = 1'b1;
    coef_addr = 3'(a);
    coef_wdata = 8'(v);
    tick();
    cw[i] = 1'b0;
  endtask
  task automatic put(input int i, input int x);
    int n;
    n = 0;
    in_data = 8'(x);
    iv[i] = 1'b1;
    while (!ir[i] && n < 50) begin
      tick();
      n++;
    end
    if (!ir[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL put_ready inst %0d: in_ready=0 after 50 cycles, required 1", i);
    end
    tick();
    iv[i] = 1'b0;
  endtask
  task automatic get(input int i, output int y, output int lat);
    lat = 0;
    while (!ov[i] && lat < 50) begin
      tick();
      lat++;
    end
    if (!ov[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL get_valid inst %0d: out_valid=0 after 50 cycles, required 1", i);
    end
    y = int'($signed(od[i]));
    tick();
  endtask
  task automatic test_reset();
    tick();
    tick();
    res = 1'b0;
    vectors += 4;
    if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", ir[0]); end
    if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", ov[0]); end
    if ($signed(od[0]) !== 16'sd0) begin miscompares++; $display("FAIL reset_out_data: got %0d, required 0", $signed(od[0])); end
    if (by[0] !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", by[0]); end
  endtask
  task automatic test_impulse();
    int exp_v[5] = '{2, 4, 6, 8, 0};
    int y, lat;
    for (int j = 0; j < 4; j++) load(0, j, 2 * (j + 1));
    for (int j = 0; j < 5; j++) begin
      put(0, (j == 0) ? 1 : 0);
      get(0, y, lat);
      vectors++;
      if (y !== exp_v[j]) begin miscompares++; $display("FAIL impulse[%0d]: got %0d, required %0d", j, y, exp_v[j]); end
      if (j == 0) begin
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL impulse_latency: got %0d cycles, required 4", lat); end
      end
    end
  endtask
  task automatic test_step();
    int stp[5] = '{20, 60, 120, 200, 200};
    int neg[4] = '{-10, -30, -60, -100};
    int y, lat;
    longint t0;
    t0 = $time;
    for (int j = 0; j < 5; j++) begin
      put(0, 10);
      get(0, y, lat);
      vectors++;
      if (y !== stp[j]) begin miscompares++; $display("FAIL step[%0d]: got %0d, required %0d", j, y, stp[j]); end
    end
    vectors++;
    if ($time - t0 !== 300) begin miscompares++; $display("FAIL throughput: 5 samples took %0d time units, required 300", $time - t0); end
    for (int j = 0; j < 4; j++) begin
      put(0, 0);
      get(0, y, lat);
    end
    for (int j = 0; j < 4; j++) begin
      put(0, -5);
      get(0, y, lat);
      vectors++;
      if (y !== neg[j]) begin miscompares++; $display("FAIL negative[%0d]: got %0d, required %0d", j, y, neg[j]); end
    end
  endtask
  task automatic test_backpressure();
    int n, y, lat;
    out_ready = 1'b0;
    put(0, 1);
    n = 0;
    while (!ov[0] && n < 50) begin
      tick();
      n++;
    end
    in_data = 8'sd2;
    iv[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      vectors += 3;
      if (ov[0] !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b, required 1", j, ov[0]); end
      if ($signed(od[0]) !== -16'sd88) begin miscompares++; $display("FAIL hold_data[%0d]: got %0d, required -88", j, $signed(od[0])); end
      if (ir[0] !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b, required 0", j, ir[0]); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors += 2;
    if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL pop_valid: got %b, required 0", ov[0]); end
    if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL pop_in_ready: got %b, required 1", ir[0]); end
    tick();
    iv[0] = 1'b0;
    vectors++;
    if (by[0] !== 1'b1) begin miscompares++; $display("FAIL held_accept_busy: got %b, required 1", by[0]); end
    get(0, y, lat);
    vectors += 2;
    if (y !== -62) begin miscompares++; $display("FAIL held_sample_result: got %0d, required -62", y); end
    if (lat !== 4) begin miscompares++; $display("FAIL held_sample_latency: got %0d, required 4", lat); end
  endtask
  task automatic test_coef_write();
    int y, lat;
    put(0, 0);
    cw[0] = 1'b1;
    coef_addr = 3'd1;
    coef_wdata = 8'sd100;
    tick();
    tick();
    cw[0] = 1'b0;
    get(0, y, lat);
    vectors++;
    if (y !== -26) begin miscompares++; $display("FAIL coef_we_in_mac: got %0d, required -26", y); end
    put(0, 0);
    get(0, y, lat);
    vectors++;
    if (y !== 20) begin miscompares++; $display("FAIL coef_unchanged: got %0d, required 20", y); end
    cw[0] = 1'b1;
    coef_addr = 3'd0;
    coef_wdata = 8'sd3;
    put(0, 1);
    cw[0] = 1'b0;
    get(0, y, lat);
    vectors++;
    if (y !== 19) begin miscompares++; $display("FAIL coef_same_cycle: got %0d, required 19", y); end
  endtask
  task automatic test_reset_mid_mac();
    int y, lat, seen;
    int exp_v[3] = '{4, 6, 8};
    put(0, 7);
    tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    vectors += 2;
    if (by[0] !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b, required 0", by[0]); end
    if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b, required 1", ir[0]); end
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (ov[0]) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_output: out_valid seen %0d cycles, required 0", seen); end
    put(0, 1);
    get(0, y, lat);
    vectors++;
    if (y !== 0) begin miscompares++; $display("FAIL midreset_coef_cleared: got %0d, required 0", y); end
    for (int j = 0; j < 4; j++) load(0, j, 2 * (j + 1));
    for (int j = 0; j < 3; j++) begin
      put(0, 0);
      get(0, y, lat);
      vectors++;
      if (y !== exp_v[j]) begin miscompares++; $display("FAIL midreset_impulse[%0d]: got %0d, required %0d", j, y, exp_v[j]); end
    end
  endtask
  task automatic test_saturation();
`ifdef FIR_SAT_EN
    int pos[4] = '{127, 127, 127, 127};
    int neg4 = -128;
`else
    int pos[4] = '{1, 2, 3, 4};
    int neg4 = 0;
`endif
    int y, lat;
    for (int j = 0; j < 4; j++) load(1, j, 127);
    for (int j = 0; j < 4; j++) begin
      put(1, 127);
      get(1, y, lat);
      vectors++;
      if (y !== pos[j]) begin miscompares++; $display("FAIL narrow_pos[%0d]: got %0d, required %0d", j, y, pos[j]); end
    end
    for (int j = 0; j < 4; j++) begin
      put(1, -128);
      get(1, y, lat);
    end
    vectors++;
    if (y !== neg4) begin miscompares++; $display("FAIL narrow_neg: got %0d, required %0d", y, neg4); end
  endtask
  task automatic test_rounding();
    int xin[4] = '{1, -1, 3, -3};
    int exp_v[4] = '{2, -1, 5, -4};
    int y, lat;
    load(2, 0, 6);
    for (int j = 0; j < 4; j++) begin
      put(2, xin[j]);
      get(2, y, lat);
      vectors++;
      if (y !== exp_v[j]) begin miscompares++; $display("FAIL round[%0d]: in %0d got %0d, required %0d", j, xin[j], y, exp_v[j]); end
    end
  endtask
  task automatic test_addr_range();
    int y, lat;
    for (int j = 0; j < 6; j++) load(3, j, j + 1);
    load(3, 6, 100);
    load(3, 7, 100);
    for (int j = 0; j < 6; j++) begin
      put(3, (j == 0) ? 1 : 0);
      get(3, y, lat);
      vectors++;
      if (y !== j + 1) begin miscompares++; $display("FAIL addr_range[%0d]: got %0d, required %0d", j, y, j + 1); end
      if (j == 0) begin
        vectors++;
        if (lat !== 6) begin miscompares++; $display("FAIL latency_6: got %0d, required 6", lat); end
      end
    end
  endtask
  initial begin
    #1;
    test_reset();
    test_impulse();
    test_step();
    test_backpressure();
    test_coef_write();
    test_reset_mid_mac();
    test_saturation();
    test_rounding();
    test_addr_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
